ucsbece154_imem_responder: RTL and testbench
============================================

UCSBECE154_IMEM_RESPONDER -- requirements
Module: ucsbece154_imem_responder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  BLOCK_WORDS 4: words per burst, power of 2.
  WORD_SIZE 32: data width.
  MEM_WORDS 4096: backing-store depth, power of 2.
  BASE_ADDR 32'h0: byte address of store word 0.
  FIRST_LATENCY 4: cycles from request acceptance edge to first MemDataReady, >=1.
  BEAT_GAP 1: cycles between successive MemDataReady pulses in a burst, >=1.
REQ-002 Ports (name, direction, width, meaning), one per line:
  Clk in 1: sole clock, rising edge.
  ResetN in 1: asynchronous, active-low reset.
  MemReadRequest in 1: level request from the cache, held high until the last beat is consumed.
  MemReadAddress in 32: block-aligned byte address, valid while MemReadRequest is high.
  MemDataIn out WORD_SIZE: beat data to the cache.
  MemDataReady out 1: one-cycle pulse; MemDataIn is valid this cycle.
  MemBusy out 1: high in any state other than IDLE.
  PreloadEnable in 1: backing-store write strobe.
  PreloadAddress in 32: byte address for the preload write.
  PreloadData in WORD_SIZE: preload write data.

Function
REQ-003 FSM states: IDLE, LATENCY, BEAT, GAP, DRAIN.
REQ-004 In IDLE with MemReadRequest=1 at a rising edge, the block SHALL latch MemReadAddress, zero the beat counter, load the latency counter, and enter LATENCY.
REQ-005 The first MemDataReady SHALL be high exactly FIRST_LATENCY cycles after the accept edge.
REQ-006 Beat k (0..BLOCK_WORDS-1) SHALL return store[((latched_addr - BASE_ADDR)>>2) + k], with the index taken modulo MEM_WORDS. Wrap-around past the top of the store is silent.
REQ-007 Each beat SHALL assert MemDataReady for exactly one cycle. Consecutive pulses are BEAT_GAP cycles apart; BEAT_GAP=1 gives back-to-back pulses.
REQ-008 Beats SHALL be delivered in ascending word order starting at word 0 of the block; there is no critical-word-first ordering.
REQ-009 After the last beat the block SHALL enter DRAIN. DRAIN returns to IDLE on the first edge that samples MemReadRequest=0.
REQ-010 Accepting a new request directly from DRAIN is not allowed; this prevents a stale level request from re-triggering.
REQ-011 If MemReadRequest falls during LATENCY, BEAT or GAP, the block SHALL abort to IDLE on that edge. No further MemDataReady pulses are issued for the aborted burst.
REQ-012 Changes on MemReadAddress after acceptance SHALL be ignored.
REQ-013 MemDataIn SHALL be registered. Between beats it holds its last value. It is 0 after reset.
REQ-014 A preload write SHALL commit at the rising edge where PreloadEnable=1, to index ((PreloadAddress-BASE_ADDR)>>2) mod MEM_WORDS.
REQ-015 A preload write and a beat read of the same word on the same edge SHALL return the old data. A beat on a later edge SHALL return the new data.
REQ-016 Preload writes SHALL be accepted in every state.
REQ-017 Counter widths: the latency counter is $clog2(max(FIRST_LATENCY,BEAT_GAP)+1) bits; the beat counter is $clog2(BLOCK_WORDS) bits and terminates at BLOCK_WORDS-1 without overflow.

Reset
REQ-018 ResetN=0 SHALL immediately force: state IDLE, MemDataReady=0, MemDataIn=0, MemBusy=0, both counters 0, latched address 0.
REQ-019 Reset asserted mid-burst SHALL abort the burst with no further pulses.
REQ-020 Backing-store contents SHALL NOT be cleared by reset.
REQ-021 Release of ResetN while MemReadRequest=1 SHALL start a burst on the first rising edge after release.

Structure
REQ-022 The state encoding localparams and the BLOCK_WORDS and WORD_SIZE defaults SHALL live in a shared package used by the instruction cache and this block.
REQ-023 The backing store SHALL be one sub-module, ucsbece154_imem_array: synchronous write, registered read, MEM_WORDS x WORD_SIZE.
REQ-024 The FSM and counters SHALL remain in the top module.

Verification (FIRST_LATENCY=4, BEAT_GAP=1, BASE_ADDR=0)
REQ-025 Preload words 0x10..0x13 with 0xA0..0xA3, then request 0x40 -> MemDataReady high on cycles +4..+7 with data A0, A1, A2, A3; MemBusy high from the accept edge through DRAIN.
REQ-026 Hold MemReadRequest high for 3 cycles after the last beat -> no fifth pulse; IDLE entered on the first low sample; a new request 2 cycles later restarts with latency 4.
REQ-027 Drop MemReadRequest after the second beat -> no further pulses; MemBusy low the next cycle.
REQ-028 Request address 0x3FFC with MEM_WORDS=4096 -> beats return store words 4095, 0, 1, 2 (wrap-around).
REQ-029 Assert ResetN=0 asynchronously between beats 1 and 2 -> MemDataReady=0 and MemDataIn=0 immediately; no pulses after release while the request stays low.
REQ-030 Re-run REQ-025 with BEAT_GAP=3 -> pulses on cycles +4, +7, +10, +13; a preload to word 0x12 at +8 -> the third beat returns the new value.

Source files
------------

// File: rtl/ucsbece154_imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder and the icache.
// Holds the responder state encoding and the block geometry defaults.
package ucsbece154_imem_responder_pkg;

    localparam int IMEM_BLOCK_WORDS = 4;
    localparam int IMEM_WORD_SIZE   = 32;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_LATENCY = 3'd1;
    localparam state_t S_BEAT    = 3'd2;
    localparam state_t S_GAP     = 3'd3;
    localparam state_t S_DRAIN   = 3'd4;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ucsbece154_imem.sv
// Instruction memory file slot; holds no module.
// The memory model is ucsbece154_imem_responder.

// File: rtl/ucsbece154_imem_array.sv
// Backing store for the responder: synchronous write, registered read.
// Only the read register is reset; the store contents survive reset.
module ucsbece154_imem_array #(
    parameter int WORDS = 4096,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge Clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Same-edge write and read of one word returns the old contents.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)   rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ucsbece154_imem_responder.sv
// Burst-read instruction memory model answering icache block refills.
// Returns BLOCK_WORDS beats in ascending order after a fixed latency.
module ucsbece154_imem_responder
    import ucsbece154_imem_responder_pkg::*;
#(
    parameter int          BLOCK_WORDS   = IMEM_BLOCK_WORDS,
    parameter int          WORD_SIZE     = IMEM_WORD_SIZE,
    parameter int          MEM_WORDS     = 4096,
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter int          FIRST_LATENCY = 4,
    parameter int          BEAT_GAP      = 1
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic                 MemReadRequest,
    input  logic [31:0]          MemReadAddress,
    output logic [WORD_SIZE-1:0] MemDataIn,
    output logic                 MemDataReady,
    output logic                 MemBusy,
    input  logic                 PreloadEnable,
    input  logic [31:0]          PreloadAddress,
    input  logic [WORD_SIZE-1:0] PreloadData
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int LW = $clog2(imax(FIRST_LATENCY, BEAT_GAP) + 1);
    localparam int BW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    localparam logic [LW-1:0] LAT_FIRST = LW'(FIRST_LATENCY - 1);
    localparam logic [LW-1:0] LAT_GAP   = (BEAT_GAP > 1) ? LW'(BEAT_GAP - 2) : '0;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BLOCK_WORDS - 1);

    state_t        state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [31:0]   addr_q, addr_d;
    logic          fire;
    logic [AW-1:0] base_idx;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
        end
    end

    // fire marks the edge that loads a beat and starts its one-cycle pulse.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        fire    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (MemReadRequest) begin
                    state_d = S_LATENCY;
                    addr_d  = MemReadAddress;
                    beat_d  = '0;
                    lat_d   = LAT_FIRST;
                end
            end
            S_LATENCY, S_GAP: begin
                if (!MemReadRequest) begin
                    state_d = S_IDLE;
                end else if (lat_q == '0) begin
                    state_d = S_BEAT;
                    fire    = 1'b1;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_BEAT: begin
                if (!MemReadRequest) begin
                    state_d = S_IDLE;
                end else if (beat_q == BEAT_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                    if (BEAT_GAP == 1) begin
                        state_d = S_BEAT;
                        fire    = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        lat_d   = LAT_GAP;
                    end
                end
            end
            S_DRAIN: begin
                if (!MemReadRequest) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        MemDataReady = 1'b0;
        MemBusy      = 1'b0;
        if (state_q == S_BEAT) MemDataReady = 1'b1;
        if (state_q != S_IDLE) MemBusy = 1'b1;
    end

    assign base_idx = AW'((addr_q - BASE_ADDR) >> 2);
    assign rd_idx   = base_idx + AW'(beat_d);
    assign wr_idx   = AW'((PreloadAddress - BASE_ADDR) >> 2);

    ucsbece154_imem_array #(
        .WORDS (MEM_WORDS),
        .WIDTH (WORD_SIZE),
        .AW    (AW)
    ) u_array (
        .Clk     (Clk),
        .ResetN  (ResetN),
        .we_i    (PreloadEnable),
        .waddr_i (wr_idx),
        .wdata_i (PreloadData),
        .re_i    (fire),
        .raddr_i (rd_idx),
        .rdata_o (MemDataIn)
    );

endmodule

// File: tb/tb_ucsbece154_imem_responder.sv
// Directed bench for the imem responder: a vector table on a BEAT_GAP=1
// instance plus hand sequences for reset and a BEAT_GAP=3 instance.
module tb_ucsbece154_imem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        pe;
    logic [31:0] pa, pd;
    logic [31:0] din0, din1;
    logic        rdy0, rdy1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ucsbece154_imem_responder u0 (
        .Clk(clk), .ResetN(rst_n),
        .MemReadRequest(req0), .MemReadAddress(addr0),
        .MemDataIn(din0), .MemDataReady(rdy0), .MemBusy(busy0),
        .PreloadEnable(pe), .PreloadAddress(pa), .PreloadData(pd)
    );

    ucsbece154_imem_responder #(.BEAT_GAP(3)) u1 (
        .Clk(clk), .ResetN(rst_n),
        .MemReadRequest(req1), .MemReadAddress(addr1),
        .MemDataIn(din1), .MemDataReady(rdy1), .MemBusy(busy1),
        .PreloadEnable(pe), .PreloadAddress(pa), .PreloadData(pd)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        rdy;
        logic        busy;
        logic [31:0] data;
    } vec_t;

    vec_t tv[$];

    localparam logic [31:0] JUNK = 32'hFFFF_FFF0;
    localparam logic [31:0] OTH  = 32'h0000_1234;

    function automatic void v(input logic rq, input logic [31:0] a,
                              input logic r, input logic b,
                              input logic [31:0] d);
        vec_t e;
        e.req = rq; e.addr = a; e.rdy = r; e.busy = b; e.data = d;
        tv.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pe = 1'b1; pa = a; pd = d;
        step();
        pe = 1'b0;
    endtask

    initial begin
        bit seen;
        logic [31:0] exp1 [4];
        int bi;

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; pe = 1'b0; pa = '0; pd = '0;
        step(); step();
        chk("rst rdy0", 32'(rdy0), 32'd0);
        chk("rst busy0", 32'(busy0), 32'd0);
        chk("rst din0", din0, 32'd0);
        chk("rst rdy1", 32'(rdy1), 32'd0);
        chk("rst busy1", 32'(busy1), 32'd0);
        chk("rst din1", din1, 32'd0);
        rst_n = 1'b1;

        preload(32'h40, 32'hA0); preload(32'h44, 32'hA1);
        preload(32'h48, 32'hA2); preload(32'h4C, 32'hA3);
        preload(32'h3FFC, 32'hFF);
        preload(32'h0, 32'hB0); preload(32'h4, 32'hB1);
        preload(32'h8, 32'hB2);

        // basic burst, drain held 3 cycles, restart after 2 idle cycles
        v(1, 32'h40, 0, 1, 0);
        v(1, JUNK, 0, 1, 0); v(1, JUNK, 0, 1, 0); v(1, JUNK, 0, 1, 0);
        v(1, JUNK, 1, 1, 32'hA0); v(1, JUNK, 1, 1, 32'hA1);
        v(1, JUNK, 1, 1, 32'hA2); v(1, JUNK, 1, 1, 32'hA3);
        v(1, JUNK, 0, 1, 32'hA3); v(1, JUNK, 0, 1, 32'hA3);
        v(1, JUNK, 0, 1, 32'hA3);
        v(0, JUNK, 0, 0, 32'hA3); v(0, JUNK, 0, 0, 32'hA3);
        v(1, 32'h40, 0, 1, 32'hA3);
        v(1, 32'h40, 0, 1, 32'hA3); v(1, 32'h40, 0, 1, 32'hA3);
        v(1, 32'h40, 0, 1, 32'hA3);
        v(1, 32'h40, 1, 1, 32'hA0); v(1, 32'h40, 1, 1, 32'hA1);
        v(1, 32'h40, 1, 1, 32'hA2); v(1, 32'h40, 1, 1, 32'hA3);
        v(0, 32'h40, 0, 0, 32'hA3);
        // abort after second beat
        v(1, 32'h40, 0, 1, 32'hA3);
        v(1, 32'h40, 0, 1, 32'hA3); v(1, 32'h40, 0, 1, 32'hA3);
        v(1, 32'h40, 0, 1, 32'hA3);
        v(1, 32'h40, 1, 1, 32'hA0); v(1, 32'h40, 1, 1, 32'hA1);
        v(0, 32'h40, 0, 0, 32'hA1); v(0, 32'h40, 0, 0, 32'hA1);
        // wrap past the top of the store
        v(1, 32'h3FFC, 0, 1, 32'hA1);
        v(1, OTH, 0, 1, 32'hA1); v(1, OTH, 0, 1, 32'hA1);
        v(1, OTH, 0, 1, 32'hA1);
        v(1, OTH, 1, 1, 32'hFF); v(1, OTH, 1, 1, 32'hB0);
        v(1, OTH, 1, 1, 32'hB1); v(1, OTH, 1, 1, 32'hB2);
        v(0, OTH, 0, 0, 32'hB2);

        for (int i = 0; i < tv.size(); i++) begin
            req0 = tv[i].req; addr0 = tv[i].addr;
            step();
            chk($sformatf("vec%0d rdy", i), 32'(rdy0), 32'(tv[i].rdy));
            chk($sformatf("vec%0d busy", i), 32'(busy0), 32'(tv[i].busy));
            chk($sformatf("vec%0d data", i), din0, tv[i].data);
        end

        // asynchronous reset between beats 1 and 2
        req0 = 1'b1; addr0 = 32'h40;
        for (int i = 0; i < 6; i++) step();
        chk("pre-reset beat1", din0, 32'hA1);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst rdy0", 32'(rdy0), 32'd0);
        chk("async rst din0", din0, 32'd0);
        chk("async rst busy0", 32'(busy0), 32'd0);
        req0 = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rdy0 || busy0) seen = 1'b1;
        end
        chk("no pulse after reset", 32'(seen), 32'd0);

        // release reset with request already high
        rst_n = 1'b0; req0 = 1'b1; addr0 = 32'h40;
        step();
        rst_n = 1'b1;
        step();
        chk("rel accept busy", 32'(busy0), 32'd1);
        step(); step(); step();
        chk("rel lat3 rdy", 32'(rdy0), 32'd0);
        step();
        chk("rel beat0 rdy", 32'(rdy0), 32'd1);
        chk("rel beat0 data", din0, 32'hA0);
        req0 = 1'b0;
        step();
        chk("rel abort busy", 32'(busy0), 32'd0);

        // BEAT_GAP=3 with preload during the burst
        exp1[0] = 32'hA0; exp1[1] = 32'hA1;
        exp1[2] = 32'hC2; exp1[3] = 32'hA3;
        addr1 = 32'h40;
        bi = 0;
        for (int c = 0; c < 16; c++) begin
            req1 = (c < 14);
            pe = (c == 8) || (c == 13);
            pa = (c == 8) ? 32'h48 : 32'h4C;
            pd = (c == 8) ? 32'hC2 : 32'hD3;
            step();
            chk($sformatf("gap3 c%0d rdy", c), 32'(rdy1),
                32'(c == 4 || c == 7 || c == 10 || c == 13));
            chk($sformatf("gap3 c%0d busy", c), 32'(busy1), 32'(c < 14));
            if (c == 4 || c == 7 || c == 10 || c == 13) begin
                chk($sformatf("gap3 beat%0d data", bi), din1, exp1[bi]);
                bi++;
            end
        end
        pe = 1'b0;

        // later read of the word written on the beat-3 edge sees new data
        req1 = 1'b1; addr1 = 32'h40;
        for (int i = 0; i < 14; i++) step();
        chk("gap3 rerun beat3", din1, 32'hD3);
        req1 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
